uart_cmd_decoder: RTL and testbench

- Sits directly downstream of the UART receive channel in the top-level laser/TEC controller.
- Parses 5-byte command frames from the host into DAC setpoint write requests for the 12 DAC channels: DFB1-4 = 0-3, DFBM1-4 = 4-7, TEC1-4 = 8-11.
- Returns a single ACK/NAK byte on the UART transmit channel for every completed frame.
- Feeds the DAC write arbiter via a valid/ready request port.

---
 rtl/uart_cmd_decoder.sv | 182 ++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// +----------------------------------------------------------------------------+
// | uart_cmd_decoder: parses 5-byte host frames into DAC setpoint writes and     |
// | answers each completed frame with a single ACK/NAK byte.                     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_cmd_decoder #(
  parameter int          NUM_CH         = 12,
  parameter int          TIMEOUT_CYCLES = 500000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_bits,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        rx_error,
  output logic        dac_wr_valid,
  input  logic        dac_wr_ready,
  output logic [3:0]  dac_wr_channel,
  output logic [15:0] dac_wr_code,
  output logic [7:0]  tx_bits,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] frame_err_count
);

  localparam int                 c_cnt_w        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]         c_sof          = 8'hA5;
  localparam logic [3:0]         c_cmd_write    = 4'h1;
  localparam logic [4:0]         c_num_ch       = 5'(NUM_CH);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_CMD = 3'd1,
    ST_GET_DH  = 3'd2,
    ST_GET_DL  = 3'd3,
    ST_GET_CHK = 3'd4,
    ST_ISSUE   = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           dh_q, dh_d;
  logic [7:0]           dl_q, dl_d;
  logic [c_cnt_w-1:0]   timeout_q, timeout_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 dac_wr_valid_q, dac_wr_valid_d;
  logic [3:0]           dac_wr_channel_q, dac_wr_channel_d;
  logic [15:0]          dac_wr_code_q, dac_wr_code_d;
  logic [7:0]           tx_bits_q, tx_bits_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [15:0]          frame_err_count_q, frame_err_count_d;

  logic                 byte_xfer;
  logic                 in_get;
  logic                 frame_ok;
  logic                 err_inc;

  always_comb begin
    state_d          = state_q;
    cmd_d            = cmd_q;
    dh_d             = dh_q;
    dl_d             = dl_q;
    timeout_d        = '0;
    dac_wr_valid_d   = dac_wr_valid_q;
    dac_wr_channel_d = dac_wr_channel_q;
    dac_wr_code_d    = dac_wr_code_q;
    tx_bits_d        = tx_bits_q;
    tx_valid_d       = tx_valid_q;
    err_inc          = 1'b0;

    byte_xfer = rx_valid && rx_ready_q;
    in_get    = (state_q == ST_GET_CMD) || (state_q == ST_GET_DH) ||
                (state_q == ST_GET_DL)  || (state_q == ST_GET_CHK);
    // The checksum byte is judged straight off the bus so the request can go out on the same edge.
    frame_ok  = (rx_bits == (cmd_q ^ dh_q ^ dl_q)) &&
                (cmd_q[7:4] == c_cmd_write) &&
                ({1'b0, cmd_q[3:0]} < c_num_ch);

    if (in_get) begin
      if (rx_error) begin
        state_d = ST_IDLE;
        err_inc = 1'b1;
      end else if (byte_xfer) begin
        case (state_q)
          ST_GET_CMD: begin cmd_d = rx_bits; state_d = ST_GET_DH; end
          ST_GET_DH:  begin dh_d  = rx_bits; state_d = ST_GET_DL; end
          ST_GET_DL:  begin dl_d  = rx_bits; state_d = ST_GET_CHK; end
          default: begin
            if (frame_ok) begin
              dac_wr_valid_d   = 1'b1;
              dac_wr_channel_d = cmd_q[3:0];
              dac_wr_code_d    = {dh_q, dl_q};
              state_d          = ST_ISSUE;
            end else begin
              tx_bits_d  = NAK_BYTE;
              tx_valid_d = 1'b1;
              err_inc    = 1'b1;
              state_d    = ST_RESP;
            end
          end
        endcase
      end else if (timeout_q == c_timeout_last) begin
        state_d = ST_IDLE;
        err_inc = 1'b1;
      end else begin
        timeout_d = timeout_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (byte_xfer && (rx_bits == c_sof)) state_d = ST_GET_CMD;
        end
        ST_ISSUE: begin
          if (dac_wr_ready) begin
            dac_wr_valid_d = 1'b0;
            tx_bits_d      = ACK_BYTE;
            tx_valid_d     = 1'b1;
            state_d        = ST_RESP;
          end
        end
        ST_RESP: begin
          if (tx_ready) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    rx_ready_d        = (state_d != ST_ISSUE) && (state_d != ST_RESP);
    frame_err_count_d = (err_inc && (frame_err_count_q != 16'hFFFF)) ?
                        frame_err_count_q + 16'd1 : frame_err_count_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q           <= ST_IDLE;
      cmd_q             <= '0;
      dh_q              <= '0;
      dl_q              <= '0;
      timeout_q         <= '0;
      rx_ready_q        <= 1'b1;
      dac_wr_valid_q    <= 1'b0;
      dac_wr_channel_q  <= '0;
      dac_wr_code_q     <= '0;
      tx_bits_q         <= '0;
      tx_valid_q        <= 1'b0;
      frame_err_count_q <= '0;
    end else begin
      state_q           <= state_d;
      cmd_q             <= cmd_d;
      dh_q              <= dh_d;
      dl_q              <= dl_d;
      timeout_q         <= timeout_d;
      rx_ready_q        <= rx_ready_d;
      dac_wr_valid_q    <= dac_wr_valid_d;
      dac_wr_channel_q  <= dac_wr_channel_d;
      dac_wr_code_q     <= dac_wr_code_d;
      tx_bits_q         <= tx_bits_d;
      tx_valid_q        <= tx_valid_d;
      frame_err_count_q <= frame_err_count_d;
    end
  end

  assign rx_ready        = rx_ready_q;
  assign dac_wr_valid    = dac_wr_valid_q;
  assign dac_wr_channel  = dac_wr_channel_q;
  assign dac_wr_code     = dac_wr_code_q;
  assign tx_bits         = tx_bits_q;
  assign tx_valid        = tx_valid_q;
  assign frame_err_count = frame_err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// +----------------------------------------------------------------------------+
// | tb_uart_cmd_decoder: self-checking bench for uart_cmd_decoder.               |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_cmd_decoder;

  localparam int c_timeout = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_bits = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_error = 1'b0;
  logic        dac_wr_valid;
  logic        dac_wr_ready = 1'b0;
  logic [3:0]  dac_wr_channel;
  logic [15:0] dac_wr_code;
  logic [7:0]  tx_bits;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] frame_err_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_err  = 0;

  uart_cmd_decoder #(
    .NUM_CH         (12),
    .TIMEOUT_CYCLES (c_timeout),
    .ACK_BYTE       (8'h06),
    .NAK_BYTE       (8'h15)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rx_bits         (rx_bits),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .rx_error        (rx_error),
    .dac_wr_valid    (dac_wr_valid),
    .dac_wr_ready    (dac_wr_ready),
    .dac_wr_channel  (dac_wr_channel),
    .dac_wr_code     (dac_wr_code),
    .tx_bits         (tx_bits),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .frame_err_count (frame_err_count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("rx_ready_before_byte", rx_ready, 1);
    rx_bits  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  // Reference outcome of a completed frame comes straight from the frame rules.
  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dh, input logic [7:0] dl,
                           input logic [7:0] chk, input int dstall, input int tstall);
    logic ok;
    ok = (chk == (cmd ^ dh ^ dl)) && (cmd[7:4] == 4'h1) && (int'(cmd[3:0]) < 12);
    send_byte(8'hA5, $urandom_range(0, 3));
    send_byte(cmd,   $urandom_range(0, 3));
    send_byte(dh,    $urandom_range(0, 3));
    send_byte(dl,    $urandom_range(0, 3));
    send_byte(chk,   0);
    if (ok) begin
      check_eq("wr_valid_latency", dac_wr_valid, 1);
      check_eq("tx_idle_in_issue", tx_valid, 0);
      for (int i = 0; i <= dstall; i++) begin
        check_eq("wr_channel", dac_wr_channel, cmd[3:0]);
        check_eq("wr_code", dac_wr_code, {dh, dl});
        check_eq("rx_ready_issue", rx_ready, 0);
        if (i < dstall) begin
          tick();
          check_eq("wr_valid_held", dac_wr_valid, 1);
        end
      end
      dac_wr_ready = 1'b1;
      tick();
      dac_wr_ready = 1'b0;
      check_eq("wr_valid_drop", dac_wr_valid, 0);
      check_eq("ack_valid", tx_valid, 1);
      check_eq("ack_byte", tx_bits, 8'h06);
    end else begin
      exp_err++;
      check_eq("nak_no_write", dac_wr_valid, 0);
      check_eq("nak_valid", tx_valid, 1);
      check_eq("nak_byte", tx_bits, 8'h15);
    end
    for (int i = 0; i < tstall; i++) begin
      tick();
      check_eq("tx_valid_held", tx_valid, 1);
      check_eq("rx_ready_resp", rx_ready, 0);
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check_eq("tx_valid_drop", tx_valid, 0);
    check_eq("rx_ready_idle", rx_ready, 1);
    check_eq("err_count", frame_err_count, exp_err);
  endtask

  initial begin
    logic [7:0] cmd, dh, dl, chk, junk;

    #12;
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_wr_valid", dac_wr_valid, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_channel", dac_wr_channel, 0);
    check_eq("rst_code", dac_wr_code, 0);
    check_eq("rst_tx_bits", tx_bits, 0);
    check_eq("rst_err", frame_err_count, 0);
    reset = 1'b1;
    tick();

    run_frame(8'h13, 8'h12, 8'h34, 8'h35, 0, 0);
    run_frame(8'h13, 8'h12, 8'h34, 8'h00, 0, 0);
    run_frame(8'h1C, 8'h00, 8'h01, 8'h1D, 0, 1);
    run_frame(8'h23, 8'h00, 8'h01, 8'h22, 0, 2);
    run_frame(8'h0B, 8'hFF, 8'hFF, 8'h0B, 0, 0);
    run_frame(8'h1B, 8'hFF, 8'hFF, 8'h1B, 10, 3);
    run_frame(8'h1A, 8'hA5, 8'hA5, 8'h1A, 2, 0);

    // Non-SOF bytes in IDLE are silently eaten.
    send_byte(8'h13, 0);
    send_byte(8'h00, 1);
    check_eq("idle_junk_tx", tx_valid, 0);
    check_eq("idle_junk_err", frame_err_count, exp_err);

    // Inter-byte timeout.
    send_byte(8'hA5, 0);
    send_byte(8'h13, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) check_eq("timeout_not_yet", frame_err_count, exp_err);
      if (i == 16) begin
        exp_err++;
        check_eq("timeout_err", frame_err_count, exp_err);
      end
      check_eq("timeout_no_tx", tx_valid, 0);
    end
    run_frame(8'h15, 8'hBE, 8'hEF, 8'h15 ^ 8'hBE ^ 8'hEF, 1, 1);

    // rx_error aborts a partial frame.
    send_byte(8'hA5, 0);
    send_byte(8'h13, 0);
    send_byte(8'h12, 1);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    exp_err++;
    check_eq("rxerr_err", frame_err_count, exp_err);
    check_eq("rxerr_no_tx", tx_valid, 0);
    tick();
    check_eq("rxerr_no_tx2", tx_valid, 0);
    run_frame(8'h17, 8'h55, 8'hAA, 8'h17 ^ 8'h55 ^ 8'hAA, 0, 0);

    // rx_error in IDLE is ignored.
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    check_eq("rxerr_idle", frame_err_count, exp_err);

    // rx_error coincident with a byte: byte dropped, frame aborted.
    send_byte(8'hA5, 0);
    rx_error = 1'b1;
    send_byte(8'h13, 0);
    rx_error = 1'b0;
    exp_err++;
    check_eq("rxerr_byte_err", frame_err_count, exp_err);
    run_frame(8'h10, 8'h00, 8'h00, 8'h10, 0, 0);

    // Randomized frames with junk between them.
    for (int f = 0; f < 30; f++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h00;
        send_byte(junk, $urandom_range(0, 2));
      end
      cmd = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                        : {4'h1, 4'($urandom_range(0, 15))};
      dh  = 8'($urandom_range(0, 255));
      dl  = 8'($urandom_range(0, 255));
      chk = cmd ^ dh ^ dl;
      if ($urandom_range(0, 3) == 0) chk = chk ^ 8'($urandom_range(1, 255));
      run_frame(cmd, dh, dl, chk, $urandom_range(0, 4), $urandom_range(0, 3));
    end

    // Asynchronous reset while a request is pending.
    send_byte(8'hA5, 0);
    send_byte(8'h13, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h35, 0);
    tick();
    check_eq("pre_reset_valid", dac_wr_valid, 1);
    check_eq("pre_reset_err", frame_err_count, exp_err);
    #2;
    reset = 1'b0;
    #1;
    check_eq("areset_wr_valid", dac_wr_valid, 0);
    check_eq("areset_tx_valid", tx_valid, 0);
    check_eq("areset_err", frame_err_count, 0);
    check_eq("areset_rx_ready", rx_ready, 1);
    exp_err = 0;
    #1;
    reset = 1'b1;
    tick();
    run_frame(8'h13, 8'h12, 8'h34, 8'h35, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
